// File: rtl/encoder_scan.sv
// encoder_scan: encodes a request vector into bit indices.
// The normal mode needs exactly one bit set. The priority mode reports the highest set bit.
// The scan mode walks every set bit from highest to lowest, one index per handshake.
module encoder_scan #(
    parameter  int N    = 16,
    localparam int IDXW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [1:0]      mode_sel,
    input  logic [N-1:0]    din,
    input  logic            din_valid,
    output logic            din_ready,
    output logic [IDXW-1:0] dout,
    output logic            out_en,
    input  logic            dout_ready,
    output logic            last,
    output logic            err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] SCAN = 2'd2;

    localparam logic [1:0] MODE_NORMAL = 2'd0;
    localparam logic [1:0] MODE_SCAN   = 2'd2;

    logic [1:0]      state, state_n;
    logic [N-1:0]    vec, vec_n, rem;
    logic [1:0]      mode_q, mode_n;
    logic [IDXW-1:0] dout_n;
    logic            out_en_n, last_n, err_n;

    // Highest set index. The loop walks the indices upward, so the last set bit it finds is the highest one.
    function automatic logic [IDXW-1:0] hi_idx(input logic [N-1:0] v);
        hi_idx = '0;
        for (int i = 0; i < N; i++)
            if (v[i]) hi_idx = IDXW'(i);
    endfunction

    function automatic logic one_hot(input logic [N-1:0] v);
        one_hot = (v != '0) && ((v & (v - N'(1))) == '0);
    endfunction

    // Input is only taken when idle, so an accept never overlaps a pending result.
    assign din_ready = en && (state == IDLE) && !rst;

    // Vector with the bit currently on dout removed.
    assign rem = vec & ~(N'(1) << dout);

    // Next-state and registered-output decode.
    always_comb begin
        state_n  = state;
        vec_n    = vec;
        mode_n   = mode_q;
        dout_n   = dout;
        out_en_n = out_en;
        last_n   = last;
        err_n    = 1'b0;
        case (state)
            IDLE: begin
                if (din_valid && din_ready) begin
                    vec_n  = din;
                    mode_n = mode_sel;
                    if (din == '0 || (mode_sel == MODE_NORMAL && !one_hot(din))) begin
                        err_n = 1'b1;
                    end else begin
                        out_en_n = 1'b1;
                        dout_n   = hi_idx(din);
                        if (mode_sel == MODE_SCAN) begin
                            state_n = SCAN;
                            last_n  = one_hot(din);
                        end else begin
                            // Modes 1 and 3 both act as the priority mode.
                            state_n = HOLD;
                            last_n  = 1'b1;
                        end
                    end
                end
            end
            HOLD, SCAN: begin
                if (!en || dout_ready) begin
                    state_n  = IDLE;
                    vec_n    = '0;
                    dout_n   = '0;
                    out_en_n = 1'b0;
                    last_n   = 1'b0;
                    // Only a scan-mode capture keeps walking the remaining bits, and only while en is high.
                    if (en && state == SCAN && mode_q == MODE_SCAN && rem != '0) begin
                        state_n  = SCAN;
                        vec_n    = rem;
                        dout_n   = hi_idx(rem);
                        out_en_n = 1'b1;
                        last_n   = one_hot(rem);
                    end
                end
            end
            default: begin
                state_n  = IDLE;
                out_en_n = 1'b0;
                last_n   = 1'b0;
                dout_n   = '0;
            end
        endcase
    end

    // State and output registers. Reset clears them at once and does not wait for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            vec    <= '0;
            mode_q <= '0;
            dout   <= '0;
            out_en <= 1'b0;
            last   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            vec    <= vec_n;
            mode_q <= mode_n;
            dout   <= dout_n;
            out_en <= out_en_n;
            last   <= last_n;
            err    <= err_n;
        end
    end

endmodule

// File: tb/tb_encoder_scan.sv
// Testbench for encoder_scan. It runs directed scenarios and random transactions on an N=16 instance,
// plus a short directed check on an N=10 instance. Expected indices come from a queue model of the set bits.
module tb_encoder_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, din_valid, dout_ready;
    logic [1:0]  mode_sel;
    logic [15:0] din;
    logic        din_ready, out_en, last, err;
    logic [3:0]  dout;

    logic        en10, din_valid10, dout_ready10;
    logic [1:0]  mode_sel10;
    logic [9:0]  din10;
    logic        din_ready10, out_en10, last10, err10;
    logic [3:0]  dout10;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    encoder_scan #(.N(16)) u16 (
        .clk(clk), .rst(rst), .en(en), .mode_sel(mode_sel), .din(din),
        .din_valid(din_valid), .din_ready(din_ready), .dout(dout),
        .out_en(out_en), .dout_ready(dout_ready), .last(last), .err(err)
    );

    encoder_scan #(.N(10)) u10 (
        .clk(clk), .rst(rst), .en(en10), .mode_sel(mode_sel10), .din(din10),
        .din_valid(din_valid10), .din_ready(din_ready10), .dout(dout10),
        .out_en(out_en10), .dout_ready(dout_ready10), .last(last10), .err(err10)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // The reference model is the list of indices the vector should produce. Scan mode gives every set bit,
    // highest first. Priority mode gives only the highest bit. Normal mode needs exactly one set bit.
    // Any other case is an error.
    task automatic txn(input logic [15:0] v, input logic [1:0] m, input bit stall);
        int q[$];
        bit exp_err;
        bit rdy;
        int waits;
        for (int i = 15; i >= 0; i--)
            if (v[i]) q.push_back(i);
        exp_err = (q.size() == 0) || (m == 2'd0 && q.size() != 1);
        if (!exp_err && m != 2'd2) begin
            int h;
            h = q[0];
            q.delete();
            q.push_back(h);
        end
        @(negedge clk);
        chk("ready_pre", din_ready, 1);
        din = v; mode_sel = m; din_valid = 1'b1; dout_ready = 1'b0;
        @(negedge clk);
        din_valid = 1'b0; din = 16'($urandom); mode_sel = 2'($urandom);
        if (exp_err) begin
            chk("err_pulse", err, 1);
            chk("err_no_oe", out_en, 0);
            @(negedge clk);
            chk("err_clear", err, 0);
            chk("err_oe_idle", out_en, 0);
        end else begin
            waits = 0;
            while (q.size() > 0) begin
                chk("out_en", out_en, 1);
                chk("dout", dout, q[0]);
                chk("last", last, (q.size() == 1));
                chk("no_err", err, 0);
                rdy = !stall || waits >= 3 || ($urandom_range(1, 0) == 1);
                dout_ready = rdy;
                if (rdy) begin
                    void'(q.pop_front());
                    waits = 0;
                end else begin
                    waits++;
                end
                @(negedge clk);
            end
            dout_ready = 1'b0;
            chk("done_oe", out_en, 0);
            chk("done_dout", dout, 0);
            chk("done_last", last, 0);
        end
        chk("ready_post", din_ready, 1);
    endtask

    initial begin
        logic [15:0] rv;
        rst = 1'b1; en = 1'b1; din_valid = 1'b0; dout_ready = 1'b0; mode_sel = 2'd0; din = '0;
        en10 = 1'b1; din_valid10 = 1'b0; dout_ready10 = 1'b0; mode_sel10 = 2'd0; din10 = '0;
        #1;
        chk("rst_ready", din_ready, 0);
        chk("rst_oe", out_en, 0);
        chk("rst_dout", dout, 0);
        chk("rst_last", last, 0);
        chk("rst_err", err, 0);
        chk("rst_ready10", din_ready10, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("ready_after_rst", din_ready, 1);

        // Priority mode: the highest set bit of 0x0A10 is 11.
        txn(16'h0A10, 2'd1, 1'b0);
        // Scan mode with dout_ready held high gives 15, 2, 0 back to back.
        txn(16'h8005, 2'd2, 1'b0);
        // Normal mode: a multi-hot vector is an error, and a one-hot vector encodes.
        txn(16'h0030, 2'd0, 1'b0);
        txn(16'h0020, 2'd0, 1'b0);
        // Mode 3 acts as priority mode.
        txn(16'h0006, 2'd3, 1'b0);

        // dout holds steady while dout_ready is low. Dropping en flushes the pending result.
        @(negedge clk);
        din = 16'h0111; mode_sel = 2'd2; din_valid = 1'b1; dout_ready = 1'b0;
        @(negedge clk);
        din_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("stall_oe", out_en, 1);
            chk("stall_dout", dout, 8);
            chk("stall_last", last, 0);
            @(negedge clk);
        end
        en = 1'b0;
        @(negedge clk);
        chk("flush_oe", out_en, 0);
        chk("flush_last", last, 0);
        chk("flush_dout", dout, 0);
        chk("flush_err", err, 0);
        chk("flush_ready_en0", din_ready, 0);
        // With en low, din_valid is refused and raises no error.
        din = 16'h0000; mode_sel = 2'd0; din_valid = 1'b1;
        @(negedge clk);
        chk("en0_no_err", err, 0);
        chk("en0_no_oe", out_en, 0);
        din_valid = 1'b0; en = 1'b1;
        #1 chk("en_back_ready", din_ready, 1);

        // Asserting reset mid-scan clears the outputs before the next clock edge.
        @(negedge clk);
        din = 16'h8005; mode_sel = 2'd2; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0; dout_ready = 1'b1;
        chk("pre_rst_dout", dout, 15);
        @(negedge clk);
        chk("pre_rst_dout2", dout, 2);
        #2 rst = 1'b1;
        #1;
        chk("arst_oe", out_en, 0);
        chk("arst_dout", dout, 0);
        chk("arst_last", last, 0);
        chk("arst_err", err, 0);
        chk("arst_ready", din_ready, 0);
        @(negedge clk);
        rst = 1'b0; dout_ready = 1'b0;
        for (int m = 0; m < 4; m++) txn(16'h0000, 2'(m), 1'b0);
        txn(16'h8005, 2'd2, 1'b0);

        // Random transactions with random consumer stalls.
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(3, 0))
                0: rv = 16'h0000;
                1: rv = 16'h0001 << $urandom_range(15, 0);
                default: rv = 16'($urandom);
            endcase
            txn(rv, 2'($urandom_range(3, 0)), 1'b1);
        end

        // N=10: index 9 needs the full 4-bit width.
        @(negedge clk);
        din10 = 10'h200; mode_sel10 = 2'd1; din_valid10 = 1'b1;
        @(negedge clk);
        din_valid10 = 1'b0;
        chk("n10_oe", out_en10, 1);
        chk("n10_dout", dout10, 9);
        chk("n10_last", last10, 1);
        dout_ready10 = 1'b1;
        @(negedge clk);
        chk("n10_done", out_en10, 0);
        din10 = 10'h3FF; mode_sel10 = 2'd2; din_valid10 = 1'b1;
        @(negedge clk);
        din_valid10 = 1'b0;
        for (int i = 9; i >= 0; i--) begin
            chk("n10_scan_oe", out_en10, 1);
            chk("n10_scan_dout", dout10, i);
            chk("n10_scan_last", last10, (i == 0));
            @(negedge clk);
        end
        chk("n10_scan_done", out_en10, 0);
        chk("n10_no_err", err10, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
